instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: TIMEOUT, 15, maximum WAIT cycles without mem_rvalid before error.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: fetch_req  in  1  controller request to fetch the instruction at pc; sampled only in IDLE.
REQ-006 Port: pc_write  in  1  load pc from pc_next at this edge.
REQ-007 Port: pc_next  in  32  next PC value from the datapath result bus.
REQ-008 Port: mem_req  out  1  one-cycle instruction-memory read strobe.
REQ-009 Port: mem_addr  out  32  read address; stable from mem_req until capture.
REQ-010 Port: mem_rvalid  in  1  read data valid.
REQ-011 Port: mem_rdata  in  32  read data.
REQ-012 Port: instr  out  32  instruction register.
REQ-013 Port: OPCode  out  7  instr[6:0].
REQ-014 Port: Func3  out  3  instr[14:12].
REQ-015 Port: Func7  out  7  instr[31:25].
REQ-016 Port: pc  out  32  current PC register.
REQ-017 Port: old_pc  out  32  address of the instruction held in instr.
REQ-018 Port: fetch_done  out  1  one-cycle pulse; instr/old_pc are valid.
REQ-019 Port: busy  out  1  high in REQ, WAIT and DONE.
REQ-020 Port: halted  out  1  sticky; the captured opcode was 7'd0.
REQ-021 Port: err  out  2  sticky error code: 0 none, 1 misaligned pc, 2 timeout.

Function
REQ-022 FSM states: IDLE, REQ, WAIT, DONE, HALT, ERR.
REQ-023 In IDLE, fetch_req=1 with pc[1:0]==0 latches mem_addr<=pc and moves to REQ; with pc[1:0]!=0 it sets err=1 and moves to ERR.
REQ-024 In REQ, mem_req=1 for exactly one cycle, then the FSM moves to WAIT and clears the wait counter.
REQ-025 In WAIT, mem_rvalid=1 captures instr<=mem_rdata and old_pc<=mem_addr, then the FSM moves to DONE.
REQ-026 In DONE, fetch_done=1 for one cycle; the FSM moves to HALT if OPCode==7'd0, otherwise to IDLE.
REQ-027 Latency: fetch_req at cycle N gives mem_req at N+1 and earliest fetch_done at N+3, with instr valid at N+3.
REQ-028 The wait counter is 4 bits and increments each WAIT cycle without rvalid; reaching TIMEOUT sets err=2 and moves to ERR.
REQ-029 mem_rvalid outside WAIT, including in the REQ cycle, is ignored.
REQ-030 fetch_req outside IDLE is ignored and is not queued.
REQ-031 pc_write is honoured in every state except HALT and ERR.
REQ-032 A pc_write during REQ or WAIT does not alter mem_addr or the captured old_pc.
REQ-033 When fetch_req and pc_write coincide in IDLE, the fetch uses the pre-write pc, and pc takes pc_next at the same edge.
REQ-034 HALT and ERR are terminal until rst; in them mem_req=0 and fetch_done=0.
REQ-035 OPCode, Func3 and Func7 are pure slices of instr and carry no extra latency.

Reset
REQ-036 When rst=1 at an edge: state<=IDLE, pc<=RESET_PC, instr<=0, old_pc<=0, mem_addr<=0, wait counter<=0, halted<=0, err<=0.
REQ-037 While in reset, mem_req=0, fetch_done=0 and busy=0.
REQ-038 rst in WAIT abandons the read; a later mem_rvalid is ignored because the FSM is in IDLE.

Structure
REQ-039 Shared package riscv_pkg holds the opcode constants (LUI, JAL, BRANCH, SW, LW, IMM, JALR, R_TYPE, HALT) and the fetch state enum.
REQ-040 The 4-bit wait counter with terminal-count compare is a sub-module named fetch_timeout_counter.
REQ-041 All other logic is in one module, and all registers use synchronous reset.

Verification
REQ-042 Reset, then fetch_req at cycle 1 with rvalid at cycle 3 and rdata 32'h00500093 -> mem_req at cycle 2; at cycle 4 fetch_done=1, OPCode=7'h13, Func3=0, old_pc=0.
REQ-043 pc=0x8, pc_write=1 with pc_next=0xC in the WAIT cycle -> mem_addr stays 0x8, old_pc=0x8, pc=0xC after capture.
REQ-044 pc_next=0x6 loaded, then fetch_req -> err=1, no mem_req, FSM in ERR; rst -> err=0, pc=RESET_PC.
REQ-045 fetch_req with mem_rvalid held low for 15 cycles -> err=2, busy=0; later rvalid is ignored and instr is unchanged.
REQ-046 Fetch returning rdata=0 -> fetch_done pulses and halted=1; a following fetch_req produces no mem_req.
REQ-047 mem_rvalid asserted during the REQ cycle, then again 2 cycles later with different data -> only the second word is captured.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the fetch slice.
// Holds the base opcode constants used to classify captured instructions and the
// fetch state machine encoding shared by the fetch unit.
package riscv_pkg;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] IMM    = 7'b0010011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] R_TYPE = 7'b0110011;
  // An all-zero opcode word stops the fetch unit.
  localparam logic [6:0] HALT   = 7'b0000000;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDone,
    StHalt,
    StErr
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Wait-cycle counter for the instruction fetch unit.
// Counts cycles spent waiting for read data and flags the cycle on which one
// more missing response would reach the timeout limit.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   clr_i       clear count to zero
//   en_i        increment count
//   at_limit_o  count equals Limit-1 (this wait cycle is the last one allowed)
module fetch_timeout_counter #(
  parameter int unsigned Limit = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic at_limit_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == 4'(Limit - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit.
// Fetches one 32-bit instruction per controller request through a single-strobe
// memory read, holds it in the instruction register with its address, and stops
// permanently (until reset) on a halt opcode, a misaligned PC or a read timeout.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   fetch_req             start a fetch at pc (sampled in idle only)
//   pc_write, pc_next     load pc from the datapath
//   mem_req, mem_addr     memory read strobe and address
//   mem_rvalid, mem_rdata memory read response
//   instr, OPCode, Func3, Func7, old_pc   captured instruction, fields, address
//   pc                    current program counter
//   fetch_done, busy      completion pulse and activity flag
//   halted, err           sticky halt flag and error code (1 misaligned, 2 timeout)
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic        pc_write,
  input  logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  OPCode,
  output logic [2:0]  Func3,
  output logic [6:0]  Func7,
  output logic [31:0] pc,
  output logic [31:0] old_pc,
  output logic        fetch_done,
  output logic        busy,
  output logic        halted,
  output logic [1:0]  err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  old_pc_q, old_pc_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic         halted_q, halted_d;
  logic [1:0]   err_q, err_d;

  logic cnt_clr;
  logic cnt_en;
  logic cnt_at_limit;

  fetch_timeout_counter #(
    .Limit(TIMEOUT)
  ) u_timeout (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .at_limit_o (cnt_at_limit)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    old_pc_d   = old_pc_q;
    mem_addr_d = mem_addr_q;
    halted_d   = halted_q;
    err_d      = err_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    // The PC is frozen once the unit has stopped.
    if (pc_write && (state_q != StHalt) && (state_q != StErr)) begin
      pc_d = pc_next;
    end

    case (state_q)
      StIdle: begin
        if (fetch_req) begin
          // Fetch address is the pre-write pc even if pc_write coincides.
          if (pc_q[1:0] == 2'b00) begin
            mem_addr_d = pc_q;
            state_d    = StReq;
          end else begin
            err_d   = 2'd1;
            state_d = StErr;
          end
        end
      end
      StReq: begin
        cnt_clr = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (mem_rvalid) begin
          instr_d  = mem_rdata;
          old_pc_d = mem_addr_q;
          state_d  = StDone;
        end else if (cnt_at_limit) begin
          err_d   = 2'd2;
          state_d = StErr;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StDone: begin
        if (instr_q[6:0] == HALT) begin
          halted_d = 1'b1;
          state_d  = StHalt;
        end else begin
          state_d = StIdle;
        end
      end
      StHalt, StErr: begin
        state_d = state_q;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      old_pc_q   <= '0;
      mem_addr_q <= '0;
      halted_q   <= 1'b0;
      err_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      old_pc_q   <= old_pc_d;
      mem_addr_q <= mem_addr_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

  // Strobes are masked by rst so nothing leaks out while reset is held.
  assign mem_req    = !rst && (state_q == StReq);
  assign fetch_done = !rst && (state_q == StDone);
  assign busy       = !rst && ((state_q == StReq) || (state_q == StWait) ||
                               (state_q == StDone));

  assign mem_addr = mem_addr_q;
  assign instr    = instr_q;
  assign OPCode   = instr_q[6:0];
  assign Func3    = instr_q[14:12];
  assign Func7    = instr_q[31:25];
  assign pc       = pc_q;
  assign old_pc   = old_pc_q;
  assign halted   = halted_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized fetch
// transactions, checked against a transaction-level model of the fetch rules.
module tb_instr_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic        pc_write = 1'b0;
  logic [31:0] pc_next = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instr;
  logic [6:0]  OPCode;
  logic [2:0]  Func3;
  logic [6:0]  Func7;
  logic [31:0] pc;
  logic [31:0] old_pc;
  logic        fetch_done;
  logic        busy;
  logic        halted;
  logic [1:0]  err;

  instr_fetch_unit #(
    .RESET_PC (ResetPc),
    .TIMEOUT  (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .pc_write   (pc_write),
    .pc_next    (pc_next),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .OPCode     (OPCode),
    .Func3      (Func3),
    .Func7      (Func7),
    .pc         (pc),
    .old_pc     (old_pc),
    .fetch_done (fetch_done),
    .busy       (busy),
    .halted     (halted),
    .err        (err)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Transaction-level model state.
  logic [31:0] m_pc, m_instr, m_old_pc;
  logic [1:0]  m_err;
  logic        m_halted;
  bit          m_dead;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are returned to idle values right after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    fetch_req  = 1'b0;
    pc_write   = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;
    m_pc = ResetPc; m_instr = '0; m_old_pc = '0; m_err = 2'd0; m_halted = 1'b0; m_dead = 1'b0;
    check_val("rst_pc", pc, m_pc);
    check_val("rst_instr", instr, 32'd0);
    check_val("rst_old_pc", old_pc, 32'd0);
    check_val("rst_err", {30'd0, err}, 32'd0);
    check_val("rst_halted", {31'd0, halted}, 32'd0);
  endtask

  task automatic idle_write(input logic [31:0] v);
    pc_write = 1'b1;
    pc_next  = v;
    step();
    m_pc = v;
    check_val("idle_wr_pc", pc, m_pc);
  endtask

  // One fetch transaction. delay: WAIT cycles before rvalid (>=15 means never).
  // wr_at: cycle of a pc_write relative to fetch_req (0 idle, 1 req, 2 first wait).
  task automatic fetch(input int unsigned delay, input bit early, input int wr_at,
                       input logic [31:0] wr_val, input logic [31:0] data, input bit stray);
    logic [31:0] a;
    bit          got;
    a = m_pc;
    fetch_req = 1'b1;
    if (wr_at == 0) begin pc_write = 1'b1; pc_next = wr_val; end
    step();
    if (wr_at == 0) m_pc = wr_val;
    if (a[1:0] != 2'b00) begin
      check_val("mis_err", {30'd0, err}, 32'd1);
      check_val("mis_req", {31'd0, mem_req}, 32'd0);
      check_val("mis_busy", {31'd0, busy}, 32'd0);
      m_err = 2'd1; m_dead = 1'b1;
      return;
    end
    check_val("req_strobe", {31'd0, mem_req}, 32'd1);
    check_val("req_addr", mem_addr, a);
    check_val("req_busy", {31'd0, busy}, 32'd1);
    if (early) begin mem_rvalid = 1'b1; mem_rdata = ~data; end
    if (wr_at == 1) begin pc_write = 1'b1; pc_next = wr_val; end
    step();
    if (wr_at == 1) m_pc = wr_val;
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      check_val("wait_req", {31'd0, mem_req}, 32'd0);
      check_val("wait_addr", mem_addr, a);
      check_val("wait_done", {31'd0, fetch_done}, 32'd0);
      if (k == int'(delay)) begin mem_rvalid = 1'b1; mem_rdata = data; end
      if (stray) fetch_req = 1'($urandom_range(0, 1));
      if (wr_at == 2 && k == 0) begin pc_write = 1'b1; pc_next = wr_val; end
      step();
      if (wr_at == 2 && k == 0) m_pc = wr_val;
      if (k == int'(delay)) begin
        m_instr = data; m_old_pc = a; got = 1'b1;
        check_val("done_pulse", {31'd0, fetch_done}, 32'd1);
        check_val("done_instr", instr, m_instr);
        check_val("done_opcode", {25'd0, OPCode}, {25'd0, data[6:0]});
        check_val("done_func3", {29'd0, Func3}, {29'd0, data[14:12]});
        check_val("done_func7", {25'd0, Func7}, {25'd0, data[31:25]});
        check_val("done_old_pc", old_pc, m_old_pc);
      end else if (k == 14) begin
        m_err = 2'd2; m_dead = 1'b1;
        check_val("tmo_err", {30'd0, err}, 32'd2);
        check_val("tmo_busy", {31'd0, busy}, 32'd0);
        check_val("tmo_pc", pc, m_pc);
        return;
      end
    end
    if (!got) begin
      check_val("fetch_bound", 32'd0, 32'd1);
      return;
    end
    if (stray) fetch_req = 1'b1;
    step();
    check_val("after_done", {31'd0, fetch_done}, 32'd0);
    check_val("after_pc", pc, m_pc);
    if (data[6:0] == 7'd0) begin
      m_halted = 1'b1; m_dead = 1'b1;
      check_val("halt_flag", {31'd0, halted}, 32'd1);
    end else begin
      check_val("idle_halted", {31'd0, halted}, 32'd0);
      check_val("idle_busy", {31'd0, busy}, 32'd0);
    end
    step();
    check_val("no_queued_req", {31'd0, mem_req}, 32'd0);
  endtask

  // In a terminal state, nothing the controller or memory does has any effect.
  task automatic hammer_terminal();
    for (int i = 0; i < 4; i++) begin
      fetch_req  = 1'b1;
      pc_write   = 1'b1;
      pc_next    = $urandom & 32'hFFFF_FFFC;
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom | 32'h1;
      step();
      check_val("term_req", {31'd0, mem_req}, 32'd0);
      check_val("term_done", {31'd0, fetch_done}, 32'd0);
      check_val("term_pc", pc, m_pc);
      check_val("term_instr", instr, m_instr);
      check_val("term_err", {30'd0, err}, {30'd0, m_err});
      check_val("term_halted", {31'd0, halted}, {31'd0, m_halted});
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [6:0] ops [8];
    logic [31:0] w;
    ops[0] = 7'h37; ops[1] = 7'h6F; ops[2] = 7'h63; ops[3] = 7'h23;
    ops[4] = 7'h03; ops[5] = 7'h13; ops[6] = 7'h67; ops[7] = 7'h33;
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 7)];
    return w;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic fetch with known latency.
    do_reset();
    fetch(0, 1'b0, -1, '0, 32'h0050_0093, 1'b0);

    // pc_write while waiting leaves the in-flight address alone.
    do_reset();
    idle_write(32'h8);
    fetch(1, 1'b0, 2, 32'hC, rand_word(), 1'b0);
    check_val("wr_wait_old_pc", old_pc, 32'h8);
    check_val("wr_wait_pc", pc, 32'hC);

    // Coincident fetch_req and pc_write in idle.
    fetch(2, 1'b0, 0, 32'h40, rand_word(), 1'b0);
    check_val("coinc_old_pc", old_pc, 32'hC);

    // Misaligned pc.
    idle_write(32'h6);
    fetch(0, 1'b0, -1, '0, rand_word(), 1'b0);
    hammer_terminal();
    do_reset();

    // Timeout, then late rvalid is ignored.
    fetch(20, 1'b0, -1, '0, rand_word(), 1'b0);
    hammer_terminal();

    // Halt opcode.
    do_reset();
    fetch(1, 1'b0, -1, '0, 32'h0000_0000, 1'b0);
    hammer_terminal();

    // Early rvalid in the request cycle, real data two cycles later.
    do_reset();
    fetch(1, 1'b1, -1, '0, 32'h1234_5033, 1'b0);

    // Longest successful wait.
    fetch(14, 1'b0, -1, '0, rand_word(), 1'b1);

    // Reset in WAIT abandons the read; reset masks busy immediately.
    do_reset();
    fetch_req = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    check_val("rst_wait_busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BE13;
    step();
    check_val("rst_wait_done", {31'd0, fetch_done}, 32'd0);
    check_val("rst_wait_instr", instr, 32'd0);
    m_pc = ResetPc; m_instr = '0; m_old_pc = '0; m_err = 2'd0; m_halted = 1'b0; m_dead = 1'b0;

    // Randomized transactions.
    for (int n = 0; n < 60; n++) begin
      int unsigned r;
      int unsigned dly;
      logic [31:0] wv;
      logic [31:0] dw;
      if (m_dead) begin
        hammer_terminal();
        do_reset();
      end
      r   = $urandom_range(0, 99);
      dly = (r < 80) ? $urandom_range(0, 5) : $urandom_range(12, 17);
      wv  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) wv[1:0] = 2'b10;
      dw  = ($urandom_range(0, 19) == 0) ? 32'h0 : rand_word();
      if ($urandom_range(0, 9) == 0) idle_write($urandom & 32'hFFFF_FFFC);
      fetch(dly, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 3 ? -1 :
            int'($urandom_range(0, 2)), wv, dw, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
